// File: rtl/serial_tx.sv
// serial_tx -- parallel-to-serial frame transmitter.
//
// Takes one DATA_WIDTH-bit word per valid/ready handshake and sends it on a
// single registered line as: start bit (0), DATA_WIDTH data bits LSB first,
// stop bit (1). Every bit is held for BIT_CYCLES clocks. The line idles high.
//
// Ports:
//   CLK    in   rising-edge clock
//   RST    in   synchronous reset, active high
//   VALID  in   DATA holds a word to send
//   DATA   in   payload, sampled only on the accept edge
//   READY  out  word can be accepted this cycle (decoded from state and RST)
//   OUT    out  serial line, registered, idles high
//   BUSY   out  frame in progress, registered
module serial_tx #(
   parameter int DATA_WIDTH = 8,
   parameter int BIT_CYCLES = 4
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  VALID,
   input  logic [DATA_WIDTH-1:0] DATA,
   output logic                  READY,
   output logic                  OUT,
   output logic                  BUSY
);

   // Counter widths are kept at least 1 bit so BIT_CYCLES=1 / DATA_WIDTH=1
   // still elaborate; the counters then simply stay at 0.
   localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
   localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CW-1:0] BC_LAST  = CW'(BIT_CYCLES - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(DATA_WIDTH - 1);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

   state_t                state, state_nxt;
   logic [CW-1:0]         bcnt, bcnt_nxt;
   logic [IW-1:0]         idx, idx_nxt;
   logic [DATA_WIDTH-1:0] sh, sh_nxt, sh_shift;
   logic                  out_q, out_nxt;
   logic                  busy_q, busy_nxt;
   logic                  bit_end;

   // READY has no path from VALID; RST forces it low so nothing is accepted
   // on a reset edge.
   assign READY    = (state == S_IDLE) && !RST;
   assign OUT      = out_q;
   assign BUSY     = busy_q;
   assign bit_end  = (bcnt == BC_LAST);
   assign sh_shift = sh >> 1;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state  <= S_IDLE;
         bcnt   <= '0;
         idx    <= '0;
         sh     <= '0;
         out_q  <= 1'b1;
         busy_q <= 1'b0;
      end else begin
         state  <= state_nxt;
         bcnt   <= bcnt_nxt;
         idx    <= idx_nxt;
         sh     <= sh_nxt;
         out_q  <= out_nxt;
         busy_q <= busy_nxt;
      end
   end

   // OUT is registered, so each branch computes the level the line must
   // carry after the coming edge (i.e. the bit of the next state).
   always_comb begin
      state_nxt = state;
      bcnt_nxt  = bcnt;
      idx_nxt   = idx;
      sh_nxt    = sh;
      out_nxt   = out_q;
      busy_nxt  = busy_q;
      case (state)
         S_IDLE: begin
            out_nxt  = 1'b1;
            busy_nxt = 1'b0;
            if (VALID && READY) begin
               sh_nxt    = DATA;
               bcnt_nxt  = '0;
               idx_nxt   = '0;
               state_nxt = S_START;
               out_nxt   = 1'b0;
               busy_nxt  = 1'b1;
            end
         end
         S_START: begin
            if (bit_end) begin
               bcnt_nxt  = '0;
               state_nxt = S_DATA;
               out_nxt   = sh[0];
            end else begin
               bcnt_nxt  = bcnt + CW'(1);
            end
         end
         S_DATA: begin
            if (bit_end) begin
               bcnt_nxt = '0;
               sh_nxt   = sh_shift;
               if (idx == IDX_LAST) begin
                  idx_nxt   = '0;
                  state_nxt = S_STOP;
                  out_nxt   = 1'b1;
               end else begin
                  idx_nxt   = idx + IW'(1);
                  out_nxt   = sh_shift[0];
               end
            end else begin
               bcnt_nxt = bcnt + CW'(1);
            end
         end
         S_STOP: begin
            if (bit_end) begin
               bcnt_nxt  = '0;
               state_nxt = S_IDLE;
               out_nxt   = 1'b1;
               busy_nxt  = 1'b0;
            end else begin
               bcnt_nxt  = bcnt + CW'(1);
            end
         end
         default: begin
            state_nxt = S_IDLE;
            out_nxt   = 1'b1;
            busy_nxt  = 1'b0;
         end
      endcase
   end

endmodule
